// File: rtl/cmd_init_sequencer.sv
// SD card identification sequencer: drives the command block through
// CMD0, CMD8, CMD55/ACMD41 (until ready), CMD2 and CMD3, then captures the RCA.
module cmd_init_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned MAX_RETRIES    = 100,
   parameter int unsigned GAP_CYCLES     = 8
) (
   input  logic        iClock_host,
   input  logic        iReset,
   input  logic        iStart,
   input  logic        iCommand_complete,
   input  logic        iCommand_index_error,
   input  logic [47:0] iResponse,
   output logic        oNew_command,
   output logic [5:0]  oCmd_index,
   output logic [31:0] oCmd_argument,
   output logic        oTimeout_enable,
   output logic        oBusy,
   output logic        oDone,
   output logic        oError,
   output logic [2:0]  oError_code,
   output logic [15:0] oRca
);

   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {
      StIdle, StIssue, StWait, StCheck, StGap, StDone, StError
   } state_t;

   typedef enum logic [2:0] {
      StepCmd0, StepCmd8, StepCmd55, StepAcmd41, StepCmd2, StepCmd3
   } step_t;

   state_t            r_state;
   step_t             r_step;
   logic [TmoW-1:0]   r_tmo_cnt;
   logic [GapW-1:0]   r_gap_cnt;
   logic [7:0]        r_retry;
   logic              r_final;
   logic              r_idx_err;
   logic [11:0]       r_resp_echo;
   logic              r_resp_ready;
   logic [15:0]       r_resp_rca;
   logic              r_new_command;
   logic [5:0]        r_cmd_index;
   logic [31:0]       r_cmd_argument;
   logic              r_timeout_enable;
   logic              r_busy;
   logic              r_done;
   logic              r_error;
   logic [2:0]        r_error_code;
   logic [15:0]       r_rca;

   step_t             w_issue_step;
   logic [5:0]        w_idx;
   logic [31:0]       w_arg;
   logic              w_unused;

   // Response bits the sequence never inspects.
   assign w_unused = ^{iResponse[47:40], iResponse[23:20], iResponse[7:0]};

   // Index/argument for the command about to be issued (CMD0 when starting).
   always_comb begin
      w_issue_step = (r_state == StGap) ? r_step : StepCmd0;
      w_idx        = 6'd0;
      w_arg        = 32'h0000_0000;
      case (w_issue_step)
         StepCmd8:   begin w_idx = 6'd8;  w_arg = 32'h0000_01AA; end
         StepCmd55:  begin w_idx = 6'd55; end
         StepAcmd41: begin w_idx = 6'd41; w_arg = 32'h40FF_8000; end
         StepCmd2:   begin w_idx = 6'd2;  end
         StepCmd3:   begin w_idx = 6'd3;  end
         default:    begin w_idx = 6'd0;  end
      endcase
   end

   // Main sequencer FSM with all outputs registered.
   always_ff @(posedge iClock_host or posedge iReset) begin
      if (iReset) begin
         r_state          <= StIdle;
         r_step           <= StepCmd0;
         r_tmo_cnt        <= '0;
         r_gap_cnt        <= '0;
         r_retry          <= 8'd0;
         r_final          <= 1'b0;
         r_idx_err        <= 1'b0;
         r_resp_echo      <= 12'd0;
         r_resp_ready     <= 1'b0;
         r_resp_rca       <= 16'd0;
         r_new_command    <= 1'b0;
         r_cmd_index      <= 6'd0;
         r_cmd_argument   <= 32'd0;
         r_timeout_enable <= 1'b0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
         r_error          <= 1'b0;
         r_error_code     <= 3'd0;
         r_rca            <= 16'd0;
      end else begin
         r_new_command <= 1'b0;
         case (r_state)
            StIdle, StDone, StError: begin
               if (iStart) begin
                  r_done           <= 1'b0;
                  r_error          <= 1'b0;
                  r_error_code     <= 3'd0;
                  r_busy           <= 1'b1;
                  r_timeout_enable <= 1'b1;
                  r_step           <= StepCmd0;
                  r_retry          <= 8'd0;
                  r_final          <= 1'b0;
                  r_new_command    <= 1'b1;
                  r_cmd_index      <= w_idx;
                  r_cmd_argument   <= w_arg;
                  r_tmo_cnt        <= TmoW'(TIMEOUT_CYCLES);
                  r_state          <= StIssue;
               end
            end
            // Counter already loaded on entry so the issue cycle counts toward the window.
            StIssue: begin
               r_tmo_cnt <= r_tmo_cnt - TmoW'(1);
               r_state   <= StWait;
            end
            StWait: begin
               r_tmo_cnt <= r_tmo_cnt - TmoW'(1);
               if (iCommand_complete) begin
                  r_idx_err    <= iCommand_index_error;
                  r_resp_echo  <= iResponse[19:8];
                  r_resp_ready <= iResponse[39];
                  r_resp_rca   <= iResponse[39:24];
                  r_state      <= StCheck;
               end else if (r_tmo_cnt == TmoW'(1)) begin
                  r_state          <= StError;
                  r_error          <= 1'b1;
                  r_error_code     <= 3'd1;
                  r_busy           <= 1'b0;
                  r_timeout_enable <= 1'b0;
               end
            end
            StCheck: begin
               r_state   <= StGap;
               r_gap_cnt <= GapW'(GAP_CYCLES - 1);
               if (r_idx_err && (r_step != StepCmd0) && (r_step != StepCmd2)) begin
                  r_state          <= StError;
                  r_error          <= 1'b1;
                  r_error_code     <= 3'd2;
                  r_busy           <= 1'b0;
                  r_timeout_enable <= 1'b0;
               end else begin
                  case (r_step)
                     StepCmd0: r_step <= StepCmd8;
                     StepCmd8: begin
                        if (r_resp_echo != 12'h1AA) begin
                           r_state          <= StError;
                           r_error          <= 1'b1;
                           r_error_code     <= 3'd3;
                           r_busy           <= 1'b0;
                           r_timeout_enable <= 1'b0;
                        end else begin
                           r_step <= StepCmd55;
                        end
                     end
                     StepCmd55: r_step <= StepAcmd41;
                     StepAcmd41: begin
                        if (!r_resp_ready) begin
                           r_retry <= r_retry + 8'd1;
                           if ((r_retry + 8'd1) == 8'(MAX_RETRIES)) begin
                              r_state          <= StError;
                              r_error          <= 1'b1;
                              r_error_code     <= 3'd4;
                              r_busy           <= 1'b0;
                              r_timeout_enable <= 1'b0;
                           end else begin
                              r_step <= StepCmd55;
                           end
                        end else begin
                           r_step <= StepCmd2;
                        end
                     end
                     StepCmd2: r_step <= StepCmd3;
                     default: begin
                        r_rca   <= r_resp_rca;
                        r_final <= 1'b1;
                     end
                  endcase
               end
            end
            StGap: begin
               if (r_gap_cnt == GapW'(0)) begin
                  if (r_final) begin
                     r_state          <= StDone;
                     r_done           <= 1'b1;
                     r_busy           <= 1'b0;
                     r_timeout_enable <= 1'b0;
                  end else begin
                     r_new_command  <= 1'b1;
                     r_cmd_index    <= w_idx;
                     r_cmd_argument <= w_arg;
                     r_tmo_cnt      <= TmoW'(TIMEOUT_CYCLES);
                     r_state        <= StIssue;
                  end
               end else begin
                  r_gap_cnt <= r_gap_cnt - GapW'(1);
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign oNew_command    = r_new_command;
   assign oCmd_index      = r_cmd_index;
   assign oCmd_argument   = r_cmd_argument;
   assign oTimeout_enable = r_timeout_enable;
   assign oBusy           = r_busy;
   assign oDone           = r_done;
   assign oError          = r_error;
   assign oError_code     = r_error_code;
   assign oRca            = r_rca;

endmodule

// File: tb/tb_cmd_init_sequencer.sv
// Bench for cmd_init_sequencer: a card responder with randomized latency and
// payload, checked against a command-list model of the identification sequence.
module tb_cmd_init_sequencer;

   localparam int TMO  = 24;
   localparam int MAXR = 4;
   localparam int GAPC = 4;
   localparam int BUDGET = 3000;

   logic        clk;
   logic        iReset;
   logic        iStart;
   logic        iCommand_complete;
   logic        iCommand_index_error;
   logic [47:0] iResponse;
   logic        oNew_command;
   logic [5:0]  oCmd_index;
   logic [31:0] oCmd_argument;
   logic        oTimeout_enable;
   logic        oBusy;
   logic        oDone;
   logic        oError;
   logic [2:0]  oError_code;
   logic [15:0] oRca;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int exp_code;
   logic [15:0] last_rca = 16'd0;

   cmd_init_sequencer #(
      .TIMEOUT_CYCLES(TMO),
      .MAX_RETRIES   (MAXR),
      .GAP_CYCLES    (GAPC)
   ) u_dut (
      .iClock_host         (clk),
      .iReset              (iReset),
      .iStart              (iStart),
      .iCommand_complete   (iCommand_complete),
      .iCommand_index_error(iCommand_index_error),
      .iResponse           (iResponse),
      .oNew_command        (oNew_command),
      .oCmd_index          (oCmd_index),
      .oCmd_argument       (oCmd_argument),
      .oTimeout_enable     (oTimeout_enable),
      .oBusy               (oBusy),
      .oDone               (oDone),
      .oError              (oError),
      .oError_code         (oError_code),
      .oRca                (oRca)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] exp_arg(input int idx);
      case (idx)
         8:       return 32'h0000_01AA;
         41:      return 32'h40FF_8000;
         default: return 32'h0000_0000;
      endcase
   endfunction

   // Expected issued-command list and final code, straight from the sequence rules.
   function automatic void model(input int busy_n, input int bad_echo,
                                 input int idx_err_cmd, input int no_resp_cmd);
      int att;
      exp_q.delete();
      exp_code = 0;
      exp_q.push_back(0);
      exp_q.push_back(8);
      if (no_resp_cmd == 8) begin exp_code = 1; return; end
      if (idx_err_cmd == 8) begin exp_code = 2; return; end
      if (bad_echo != 0)    begin exp_code = 3; return; end
      att = 0;
      while (1) begin
         exp_q.push_back(55);
         if (idx_err_cmd == 55) begin exp_code = 2; return; end
         exp_q.push_back(41);
         att++;
         if (idx_err_cmd == 41) begin exp_code = 2; return; end
         if (att > busy_n) break;
         if (att == MAXR) begin exp_code = 4; return; end
      end
      exp_q.push_back(2);
      exp_q.push_back(3);
      if (idx_err_cmd == 3) exp_code = 2;
   endfunction

   // One start-to-finish run; entered and left on a negative edge.
   task automatic run_seq(input int busy_n, input int bad_echo, input int idx_err_cmd,
                          input int no_resp_cmd, input bit do_reset, input bit extras,
                          input int fixed_lat, input logic [15:0] rca_val);
      int n, cyc, att, idx, lat, waitc;
      bit aborted;
      logic [47:0] resp;
      logic ie;
      model(busy_n, bad_echo, idx_err_cmd, no_resp_cmd);
      n = 0; cyc = 0; att = 0; aborted = 0;
      iStart = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
      while (cyc < BUDGET) begin
         if (oNew_command === 1'b1) begin
            idx = int'(oCmd_index);
            chk("cmd_index", 64'(idx), (n < exp_q.size()) ? 64'(exp_q[n]) : 64'd99);
            chk("cmd_arg", 64'(oCmd_argument), 64'(exp_arg(idx)));
            chk("busy_at_issue", 64'(oBusy), 64'd1);
            chk("tmo_en_at_issue", 64'(oTimeout_enable), 64'd1);
            n++;
            @(negedge clk); cyc++;
            chk("issue_pulse_width", 64'(oNew_command), 64'd0);
            if (do_reset && idx == 41) begin
               @(negedge clk);
               iReset = 1'b1;
               #1;
               chk("rst_outputs", {oNew_command, oTimeout_enable, oBusy, oDone, oError,
                                   oError_code, oCmd_index, oCmd_argument, oRca}, 64'd0);
               @(negedge clk);
               iReset = 1'b0;
               last_rca = 16'd0;
               aborted = 1;
               break;
            end
            if (idx == no_resp_cmd) begin
               repeat (TMO - 2) @(negedge clk);
               cyc += TMO - 2;
               chk("timeout_not_early", 64'(oError), 64'd0);
               @(negedge clk); cyc++;
               chk("timeout_exact", 64'(oError), 64'd1);
            end else begin
               lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(20, 3));
               waitc = lat - 1;
               if (extras && idx == 55) begin
                  iStart = 1'b1;
                  @(negedge clk); cyc++;
                  iStart = 1'b0;
                  waitc--;
               end
               repeat (waitc) @(negedge clk);
               cyc += waitc;
               resp = {16'($urandom), $urandom};
               if (idx == 8) resp[19:8] = (bad_echo != 0) ? 12'h1AB : 12'h1AA;
               if (idx == 41) begin
                  att++;
                  resp[39] = (att <= busy_n) ? 1'b0 : 1'b1;
               end
               if (idx == 3) resp[39:24] = rca_val;
               if (idx == idx_err_cmd) ie = 1'b1;
               else if (idx == 0 || idx == 2) ie = 1'($urandom_range(1, 0));
               else ie = 1'b0;
               iResponse = resp;
               iCommand_index_error = ie;
               iCommand_complete = 1'b1;
               @(negedge clk); cyc++;
               iCommand_complete = 1'b0;
               iCommand_index_error = 1'b0;
               iResponse = {16'($urandom), $urandom};
               if (extras) begin
                  // Stray completion while the sequencer is not waiting.
                  @(negedge clk); cyc++;
                  iCommand_index_error = 1'b1;
                  iCommand_complete = 1'b1;
                  @(negedge clk); cyc++;
                  iCommand_complete = 1'b0;
                  iCommand_index_error = 1'b0;
               end
            end
         end else if (oBusy !== 1'b1) begin
            break;
         end
         @(negedge clk); cyc++;
      end
      chk("cycle_bound", 64'(cyc < BUDGET), 64'd1);
      if (!aborted) begin
         chk("issued_count", 64'(n), 64'(exp_q.size()));
         chk("done", 64'(oDone), 64'(exp_code == 0));
         chk("error", 64'(oError), 64'(exp_code != 0));
         chk("error_code", 64'(oError_code), 64'(exp_code));
         chk("busy_end", 64'(oBusy), 64'd0);
         chk("tmo_en_end", 64'(oTimeout_enable), 64'd0);
         chk("index_held", 64'(oCmd_index), 64'(exp_q[exp_q.size() - 1]));
         if (exp_code == 0) last_rca = rca_val;
         chk("rca", 64'(oRca), 64'(last_rca));
      end
   endtask

   initial begin
      int busy_n, sel, iec, nrc, be;
      iReset = 1'b0;
      iStart = 1'b0;
      iCommand_complete = 1'b0;
      iCommand_index_error = 1'b0;
      iResponse = 48'd0;
      #1 iReset = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {oNew_command, oTimeout_enable, oBusy, oDone, oError,
                            oError_code, oCmd_index, oCmd_argument, oRca}, 64'd0);
      iReset = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_no_issue", {63'd0, oNew_command | oBusy}, 64'd0);

      // Happy path with fixed latency, ignored iStart and stray completions.
      run_seq(0, 0, -1, -1, 0, 1, 20, 16'hB368);
      // Busy card three times, then ready.
      run_seq(3, 0, -1, -1, 0, 0, 0, 16'($urandom));
      // Card never ready: retries exhausted, RCA untouched.
      run_seq(99, 0, -1, -1, 0, 0, 0, 16'($urandom));
      // No response to CMD8.
      run_seq(0, 0, -1, 8, 0, 0, 0, 16'($urandom));
      // Bad CMD8 echo.
      run_seq(0, 1, -1, -1, 0, 0, 0, 16'($urandom));
      // Index error on CMD55.
      run_seq(0, 0, 55, -1, 0, 0, 0, 16'($urandom));
      // Reset while waiting on ACMD41, then restart.
      run_seq(1, 0, -1, -1, 1, 0, 0, 16'($urandom));
      @(negedge clk);
      run_seq(0, 0, -1, -1, 0, 0, 0, 16'($urandom));

      // Randomized sequences.
      for (int r = 0; r < 6; r++) begin
         busy_n = int'($urandom_range(5, 0));
         sel = int'($urandom_range(4, 0));
         be = (sel == 1) ? 1 : 0;
         nrc = (sel == 3) ? 8 : -1;
         iec = -1;
         if (sel == 2) begin
            case ($urandom_range(3, 0))
               0: iec = 8;
               1: iec = 55;
               2: iec = 41;
               default: iec = 3;
            endcase
         end
         run_seq(busy_n, be, iec, nrc, 0, 0, 0, 16'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
